// File: rtl/plic_pkg.sv
// Shared constants for the PLIC: address window, register offsets and the
// byte-strobe helper used by the register file.
package plic_pkg;

    localparam int ID_W = 5;

    localparam logic [31:0] plic_base_addr     = 32'h0C00_0000;
    localparam logic [31:0] plic_top_addr      = 32'h1000_0000;

    localparam logic [31:0] plic_priority_off  = 32'h0000_0000;
    localparam logic [31:0] plic_pending_off   = 32'h0000_1000;
    localparam logic [31:0] plic_enable_off    = 32'h0000_2000;
    localparam logic [31:0] plic_threshold_off = 32'h0020_0000;
    localparam logic [31:0] plic_claim_off     = 32'h0020_0004;

    // True when the byte lane holding bit position bit_pos is strobed.
    function automatic logic strobe_hit(input logic [3:0] wstrb, input logic [4:0] bit_pos);
        return wstrb[bit_pos[4:3]];
    endfunction

endpackage

// File: rtl/plic_if.sv
// Valid/ready peripheral bus as seen by the PLIC slot of the interconnect.
interface plic_if;

    logic        plic_valid;
    logic        plic_instr;
    logic [31:0] plic_addr;
    logic [31:0] plic_wdata;
    logic [3:0]  plic_wstrb;
    logic [31:0] plic_rdata;
    logic        plic_ready;

    modport master (
        output plic_valid, plic_instr, plic_addr, plic_wdata, plic_wstrb,
        input  plic_rdata, plic_ready
    );

    modport slave (
        input  plic_valid, plic_instr, plic_addr, plic_wdata, plic_wstrb,
        output plic_rdata, plic_ready
    );

endinterface

// File: rtl/plic_arbiter.sv
// Combinational selection of the highest-priority eligible source above the
// threshold; equal priorities resolve to the lowest ID.
module plic_arbiter
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic [NSRC-1:0]        eligible,
    input  logic [NSRC*PRIO_W-1:0] prio_flat,
    input  logic [PRIO_W-1:0]      threshold,
    output logic [ID_W-1:0]        best_id,
    output logic [PRIO_W-1:0]      best_prio
);

    logic [PRIO_W-1:0] bar;

    // Strict greater-than against the running bar keeps the earlier (lower) ID on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        bar       = threshold;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (prio_flat[i*PRIO_W +: PRIO_W] > bar)) begin
                best_id   = ID_W'(i + 1);
                best_prio = prio_flat[i*PRIO_W +: PRIO_W];
                bar       = prio_flat[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/plic.sv
// Platform-level interrupt controller: level gateways, priority/enable/threshold
// registers and claim/complete for a single M-mode context.
module plic
    import plic_pkg::*;
#(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 3
) (
    input  logic            clock,
    input  logic            reset,
    plic_if.slave           bus,
    input  logic [NSRC-1:0] plic_src,
    output logic            plic_meip
);

    logic [PRIO_W-1:0] prio_q [NSRC];
    logic [PRIO_W-1:0] prio_d [NSRC];
    logic [NSRC-1:0]   pending_q, pending_d;
    logic [NSRC-1:0]   enable_q, enable_d;
    logic [NSRC-1:0]   in_flight_q, in_flight_d;
    logic [PRIO_W-1:0] threshold_q, threshold_d;
    logic              ready_q;
    logic              meip_q;
    logic [31:0]       rdata_q, rdata_d;

    logic [NSRC*PRIO_W-1:0] prio_flat;
    logic [ID_W-1:0]        best_id;
    logic [PRIO_W-1:0]      best_prio;

    logic [31:0] word_addr;
    logic [9:0]  prio_idx;
    logic        in_prio_page;
    logic        sel_pending, sel_enable, sel_threshold, sel_claim;
    logic        rd_req, wr_req;
    logic        unused_ok;

    assign word_addr     = {bus.plic_addr[31:2], 2'b00};
    assign prio_idx      = word_addr[11:2];
    assign in_prio_page  = (word_addr[31:12] == plic_priority_off[31:12]);
    assign sel_pending   = (word_addr == plic_pending_off);
    assign sel_enable    = (word_addr == plic_enable_off);
    assign sel_threshold = (word_addr == plic_threshold_off);
    assign sel_claim     = (word_addr == plic_claim_off);
    assign rd_req        = bus.plic_valid && (bus.plic_wstrb == 4'h0);
    assign wr_req        = bus.plic_valid && (bus.plic_wstrb != 4'h0);

    // Fetches are served exactly like loads, so the instruction flag is not decoded.
    assign unused_ok = ^{bus.plic_instr, bus.plic_addr[1:0], bus.plic_wdata, best_prio};

    always_comb begin
        prio_flat = '0;
        for (int i = 0; i < NSRC; i++) begin
            prio_flat[i*PRIO_W +: PRIO_W] = prio_q[i];
        end
    end

    plic_arbiter #(
        .NSRC   (NSRC),
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .eligible  (pending_q & enable_q),
        .prio_flat (prio_flat),
        .threshold (threshold_q),
        .best_id   (best_id),
        .best_prio (best_prio)
    );

    // Read mux; priority slot 0 and unmapped offsets fall through to zero.
    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            if (in_prio_page) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (prio_idx == 10'(i + 1)) begin
                        rdata_d[PRIO_W-1:0] = prio_q[i];
                    end
                end
            end else if (sel_pending) begin
                rdata_d[NSRC:1] = pending_q;
            end else if (sel_enable) begin
                rdata_d[NSRC:1] = enable_q;
            end else if (sel_threshold) begin
                rdata_d[PRIO_W-1:0] = threshold_q;
            end else if (sel_claim) begin
                rdata_d[ID_W-1:0] = best_id;
            end
        end
    end

    // Gateways re-arm only once a source is neither pending nor in flight, so a
    // held level cannot re-pend until its completion has been written.
    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        in_flight_d = in_flight_q;
        pending_d   = pending_q | (plic_src & ~in_flight_q & ~pending_q);

        if (wr_req) begin
            if (in_prio_page) begin
                for (int i = 0; i < NSRC; i++) begin
                    for (int j = 0; j < PRIO_W; j++) begin
                        if ((prio_idx == 10'(i + 1)) && strobe_hit(bus.plic_wstrb, 5'(j))) begin
                            prio_d[i][j] = bus.plic_wdata[j];
                        end
                    end
                end
            end else if (sel_enable) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (strobe_hit(bus.plic_wstrb, 5'(i + 1))) begin
                        enable_d[i] = bus.plic_wdata[i + 1];
                    end
                end
            end else if (sel_threshold) begin
                for (int j = 0; j < PRIO_W; j++) begin
                    if (strobe_hit(bus.plic_wstrb, 5'(j))) begin
                        threshold_d[j] = bus.plic_wdata[j];
                    end
                end
            end else if (sel_claim && bus.plic_wstrb[0]) begin
                for (int i = 0; i < NSRC; i++) begin
                    if (bus.plic_wdata[4:0] == 5'(i + 1)) begin
                        in_flight_d[i] = 1'b0;
                    end
                end
            end
        end

        if (rd_req && sel_claim) begin
            for (int i = 0; i < NSRC; i++) begin
                if (best_id == ID_W'(i + 1)) begin
                    pending_d[i]   = 1'b0;
                    in_flight_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSRC; i++) begin
                prio_q[i] <= '0;
            end
            pending_q   <= '0;
            enable_q    <= '0;
            in_flight_q <= '0;
            threshold_q <= '0;
        end else begin
            prio_q      <= prio_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            in_flight_q <= in_flight_d;
            threshold_q <= threshold_d;
        end
    end

    // One-cycle response pulse and the registered interrupt line to the cpu.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            meip_q  <= 1'b0;
        end else begin
            ready_q <= bus.plic_valid;
            rdata_q <= rdata_d;
            meip_q  <= (best_id != '0);
        end
    end

    assign bus.plic_ready = ready_q;
    assign bus.plic_rdata = rdata_q;
    assign plic_meip      = meip_q;

endmodule

// File: tb/tb_plic.sv
// Scenario bench for the PLIC: expected read data is queued when a request is
// issued and popped when its response pulse is sampled.
module tb_plic;

    logic       clock;
    logic       reset;
    logic [7:0] plic_src;
    logic       plic_meip;

    plic_if bus ();

    plic #(
        .NSRC   (8),
        .PRIO_W (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .plic_src  (plic_src),
        .plic_meip (plic_meip)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total;
    int          bad;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] want;
    logic        rdy;

    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb,
                              output logic [31:0] rdata, output logic ready);
        @(negedge clock);
        bus.plic_valid = 1'b1;
        bus.plic_addr  = addr;
        bus.plic_wdata = wdata;
        bus.plic_wstrb = wstrb;
        @(negedge clock);
        bus.plic_valid = 1'b0;
        bus.plic_wstrb = 4'h0;
        ready = bus.plic_ready;
        rdata = bus.plic_rdata;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] d;
        logic        r;
        bus_access(addr, wdata, wstrb, d, r);
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] expected,
                            output logic [31:0] rdata, output logic ready);
        exp_q.push_back(expected);
        bus_access(addr, 32'h0, 4'h0, rdata, ready);
    endtask

    task automatic do_reset();
        plic_src = 8'h00;
        reset    = 1'b0;
        repeat (2) @(negedge clock);
        reset    = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        plic_src = 8'hFF;
        repeat (3) @(negedge clock);
        total++;
        if (plic_meip !== 1'b0 || bus.plic_ready !== 1'b0 || bus.plic_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: meip=%b ready=%b rdata=%h want 0/0/0", plic_meip, bus.plic_ready, bus.plic_rdata);
        end
        reset = 1'b1;
        bus_read(32'h0000_1000, 32'h0000_01FE, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL reset_pending: got=%h ready=%b want=%h", got, rdy, want);
        end
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_meip_prio0: got=%b want=0", plic_meip);
        end
        plic_src = 8'h00;
    endtask

    task automatic test_single_source();
        do_reset();
        bus_write(32'h0000_000C, 32'h2, 4'hF);
        bus_write(32'h0000_2000, 32'h08, 4'hF);
        bus_write(32'h0020_0000, 32'h1, 4'hF);
        plic_src = 8'h04;
        @(negedge clock);
        plic_src = 8'h00;
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_meip_early: got=%b want=0", plic_meip);
        end
        @(negedge clock);
        total++;
        if (plic_meip !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_meip_rise: got=%b want=1", plic_meip);
        end
        bus_read(32'h0020_0004, 32'h3, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL single_claim: got=%h ready=%b want=%h", got, rdy, want);
        end
        total++;
        if (plic_meip !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_meip_lag: got=%b want=1", plic_meip);
        end
        @(negedge clock);
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_meip_fall: got=%b want=0", plic_meip);
        end
        bus_read(32'h0000_1000, 32'h0, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL single_pending_clear: got=%h ready=%b want=%h", got, rdy, want);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] order [4];
        order[0] = 32'd7;
        order[1] = 32'd2;
        order[2] = 32'd5;
        order[3] = 32'd0;
        do_reset();
        bus_write(32'h0000_0008, 32'h5, 4'hF);
        bus_write(32'h0000_0014, 32'h5, 4'hF);
        bus_write(32'h0000_001C, 32'h6, 4'hF);
        bus_write(32'h0000_2000, 32'hA4, 4'hF);
        plic_src = 8'h52;
        @(negedge clock);
        plic_src = 8'h00;
        for (int k = 0; k < 4; k++) begin
            bus_read(32'h0020_0004, order[k], got, rdy);
            want = exp_q.pop_front();
            total++;
            if (!rdy || got !== want) begin
                bad++;
                $display("[TB] FAIL arb_claim%0d: got=%h ready=%b want=%h", k, got, rdy, want);
            end
        end
    endtask

    task automatic test_threshold();
        do_reset();
        bus_write(32'h0000_0010, 32'h3, 4'hF);
        bus_write(32'h0000_2000, 32'h10, 4'hF);
        bus_write(32'h0020_0000, 32'h3, 4'hF);
        plic_src = 8'h08;
        @(negedge clock);
        plic_src = 8'h00;
        repeat (2) @(negedge clock);
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL thr_meip_blocked: got=%b want=0", plic_meip);
        end
        bus_read(32'h0020_0004, 32'h0, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL thr_claim_none: got=%h ready=%b want=%h", got, rdy, want);
        end
        bus_read(32'h0000_1000, 32'h10, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL thr_pending_kept: got=%h ready=%b want=%h", got, rdy, want);
        end
        bus_write(32'h0020_0000, 32'h2, 4'hF);
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL thr_meip_on_ready: got=%b want=0", plic_meip);
        end
        @(negedge clock);
        total++;
        if (plic_meip !== 1'b1) begin
            bad++;
            $display("[TB] FAIL thr_meip_after: got=%b want=1", plic_meip);
        end
    endtask

    task automatic test_level_retrigger();
        logic [31:0] bogus [2];
        bogus[0] = 32'd9;
        bogus[1] = 32'd0;
        do_reset();
        bus_write(32'h0000_0004, 32'h1, 4'hF);
        bus_write(32'h0000_2000, 32'h02, 4'hF);
        plic_src = 8'h01;
        repeat (2) @(negedge clock);
        bus_read(32'h0020_0004, 32'h1, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL lvl_claim: got=%h ready=%b want=%h", got, rdy, want);
        end
        repeat (2) @(negedge clock);
        bus_read(32'h0000_1000, 32'h0, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL lvl_no_repend: got=%h ready=%b want=%h", got, rdy, want);
        end
        for (int k = 0; k < 2; k++) begin
            bus_write(32'h0020_0004, bogus[k], 4'h1);
            repeat (2) @(negedge clock);
            bus_read(32'h0000_1000, 32'h0, got, rdy);
            want = exp_q.pop_front();
            total++;
            if (!rdy || got !== want) begin
                bad++;
                $display("[TB] FAIL lvl_bad_complete%0d: got=%h ready=%b want=%h", k, got, rdy, want);
            end
        end
        bus_write(32'h0020_0004, 32'h1, 4'h1);
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lvl_meip_e0: got=%b want=0", plic_meip);
        end
        @(negedge clock);
        total++;
        if (plic_meip !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lvl_meip_e1: got=%b want=0", plic_meip);
        end
        @(negedge clock);
        total++;
        if (plic_meip !== 1'b1) begin
            bad++;
            $display("[TB] FAIL lvl_meip_e2: got=%b want=1", plic_meip);
        end
        bus_read(32'h0000_1000, 32'h2, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL lvl_repend: got=%h ready=%b want=%h", got, rdy, want);
        end
        plic_src = 8'h00;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_write(32'h0000_2000, 32'hFF, 4'hF);
        bus_write(32'h0000_0004, 32'h5, 4'hF);
        bus_write(32'h0000_0000, 32'h7, 4'hF);
        bus_read(32'h0000_0000, 32'h0, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL b2b_prio0: got=%h ready=%b want=%h", got, rdy, want);
        end
        exp_q.push_back(32'hFE);
        @(negedge clock);
        bus.plic_valid = 1'b1;
        bus.plic_addr  = 32'h0000_2000;
        bus.plic_wstrb = 4'h0;
        @(negedge clock);
        want = exp_q.pop_front();
        total++;
        if (bus.plic_ready !== 1'b1 || bus.plic_rdata !== want) begin
            bad++;
            $display("[TB] FAIL b2b_first: rdata=%h ready=%b want=%h/1", bus.plic_rdata, bus.plic_ready, want);
        end
        bus.plic_addr  = 32'h0000_0004;
        bus.plic_wdata = 32'hFFFF_FFFF;
        bus.plic_wstrb = 4'h2;
        @(negedge clock);
        bus.plic_valid = 1'b0;
        bus.plic_wstrb = 4'h0;
        total++;
        if (bus.plic_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_second_ready: got=%b want=1", bus.plic_ready);
        end
        @(negedge clock);
        total++;
        if (bus.plic_ready !== 1'b0 || bus.plic_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL b2b_idle: ready=%b rdata=%h want 0/0", bus.plic_ready, bus.plic_rdata);
        end
        bus_read(32'h0000_0004, 32'h5, got, rdy);
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL b2b_prio1_kept: got=%h ready=%b want=%h", got, rdy, want);
        end
        bus.plic_instr = 1'b1;
        bus_read(32'h0000_3000, 32'h0, got, rdy);
        bus.plic_instr = 1'b0;
        want = exp_q.pop_front();
        total++;
        if (!rdy || got !== want) begin
            bad++;
            $display("[TB] FAIL b2b_unmapped: got=%h ready=%b want=%h", got, rdy, want);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b0;
        plic_src       = 8'h00;
        bus.plic_valid = 1'b0;
        bus.plic_instr = 1'b0;
        bus.plic_addr  = 32'h0;
        bus.plic_wdata = 32'h0;
        bus.plic_wstrb = 4'h0;

        test_reset();
        test_single_source();
        test_arbitration();
        test_threshold();
        test_level_retrigger();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
